sprite_rom_arbiter: RTL

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

---
 rtl/sprite_rom_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Purpose : round-robin arbiter that lets NREQ sprite fetchers share one sprite ROM in bursts.
// Latency : gnt is combinational in the grant cycle; first beat address 1 cycle later; rd_valid 1+ROM_LAT after gnt.
// Backpres: none on the read side; requesters hold req/addr/len until gnt (the only handshake).
// Ports   : req/req_addr/req_len/gnt form the request side; rom_address/rom_rden/rom_readdata drive the ROM;
//           rd_valid/rd_id/rd_last/rd_data return words tagged with their owner; busy is high during a burst.
module sprite_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 16,
  parameter int DW      = 24,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*4-1:0]         req_len,
  output logic [NREQ-1:0]           gnt,
  output logic [AW-1:0]             rom_address,
  output logic                      rom_rden,
  input  logic [DW-1:0]             rom_readdata,
  output logic                      rd_valid,
  output logic [$clog2(NREQ)-1:0]   rd_id,
  output logic                      rd_last,
  output logic [DW-1:0]             rd_data,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       beat_q, beat_d;

  // Issue-side tags delayed ROM_LAT cycles so they line up with rom_readdata.
  logic [ROM_LAT-1:0] pv_q, pv_d;
  logic [ROM_LAT-1:0] pl_q, pl_d;
  logic [IDW-1:0]     pid_q [ROM_LAT];
  logic [IDW-1:0]     pid_d [ROM_LAT];

  logic             arb_vld;
  logic [IDW-1:0]   arb_idx;
  logic [IDW:0]     cand;
  logic             final_beat;
  logic             take;
  logic [NREQ-1:0]  gnt_c;

  // Round-robin search starting just after the last winner. cand is one bit
  // wider than an index so last+k never overflows before the wrap.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!arb_vld && req[cand[IDW-1:0]]) begin
        arb_vld = 1'b1;
        arb_idx = cand[IDW-1:0];
      end
    end
  end

  assign final_beat = (state_q == BURST) && (beat_q == len_q);
  // Grants only happen when idle or on the last beat, which gives back-to-back bursts.
  assign take       = ((state_q == IDLE) || final_beat) && arb_vld;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    gnt_c   = '0;

    if (state_q == BURST) begin
      if (final_beat) begin
        // addr_q keeps the last issued address so rom_address holds while idle.
        state_d = IDLE;
      end else begin
        addr_d = addr_q + 1'b1;
        beat_d = beat_q + 4'd1;
      end
    end

    if (take) begin
      gnt_c[arb_idx] = 1'b1;
      state_d        = BURST;
      last_d         = arb_idx;
      owner_d        = arb_idx;
      addr_d         = req_addr[arb_idx*AW +: AW];
      len_d          = req_len[arb_idx*4 +: 4];
      beat_d         = 4'd0;
    end
  end

  always_comb begin
    pv_d = pv_q;
    pl_d = pl_q;
    for (int i = 0; i < ROM_LAT; i++) begin
      pid_d[i] = pid_q[i];
    end
    pv_d[0]  = rom_rden;
    pl_d[0]  = final_beat;
    pid_d[0] = owner_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pl_d[i]  = pl_q[i-1];
      pid_d[i] = pid_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ-1);
      owner_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      pv_q    <= '0;
      pl_q    <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pid_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        pid_q[i] <= pid_d[i];
      end
    end
  end

  // gnt is combinational from req, so it is forced low while reset is held.
  assign gnt         = reset ? '0 : gnt_c;
  assign rom_address = addr_q;
  assign rom_rden    = (state_q == BURST);
  assign busy        = (state_q == BURST);
  assign rd_valid    = pv_q[ROM_LAT-1];
  assign rd_last     = pl_q[ROM_LAT-1];
  assign rd_id       = pid_q[ROM_LAT-1];
  assign rd_data     = rom_readdata;

endmodule
